// File: rtl/alu_ctrl_muldiv_pkg.sv
// Shared definitions for the ALU control / iterative MUL-DIV slice:
// ALU select codes, ALUOp and M-extension funct3 encodings, sequencer states.
package alu_ctrl_muldiv_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_PASS = 4'd10
   } alu_sel_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_PASS  = 2'b11
   } aluop_e;

   typedef enum logic [2:0] {
      M_MUL    = 3'b000,
      M_MULH   = 3'b001,
      M_MULHSU = 3'b010,
      M_MULHU  = 3'b011,
      M_DIV    = 3'b100,
      M_DIVU   = 3'b101,
      M_REM    = 3'b110,
      M_REMU   = 3'b111
   } mop_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

   function automatic logic is_signed_a(mop_e op);
      return op inside {M_MUL, M_MULH, M_MULHSU, M_DIV, M_REM};
   endfunction

   function automatic logic is_signed_b(mop_e op);
      return op inside {M_MUL, M_MULH, M_DIV, M_REM};
   endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_if.sv
// Decode-to-EX bundle: instruction fields and operands in, ALU select,
// stall and MUL/DIV result out.
interface alu_ctrl_muldiv_if #(parameter int unsigned XLEN = 32);

   logic            valid_i;
   logic [1:0]      alu_op;
   logic [2:0]      funct3;
   logic            funct7_5;
   logic            funct7_0;
   logic            rtype;
   logic            itype;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [3:0]      alu_sel;
   logic            md_sel;
   logic            stall;
   logic            md_busy;
   logic            md_done;
   logic [XLEN-1:0] md_result;

   modport master (
      output valid_i, alu_op, funct3, funct7_5, funct7_0, rtype, itype, rs1_val, rs2_val,
      input  alu_sel, md_sel, stall, md_busy, md_done, md_result
   );

   modport slave (
      input  valid_i, alu_op, funct3, funct7_5, funct7_0, rtype, itype, rs1_val, rs2_val,
      output alu_sel, md_sel, stall, md_busy, md_done, md_result
   );

endinterface

// File: rtl/alu_ctrl_muldiv_seq_muldiv_core.sv
// Iterative radix-2 multiply/divide sequencer: shift-add multiply, restoring
// divide on magnitudes, sign fixup on the final step, one-cycle fast paths.
module seq_muldiv_core
   import alu_ctrl_muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            valid_i,
   input  mop_e            op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned     CW      = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e       state;
   logic [CW-1:0]   cnt;
   mop_e            op_q;
   logic            neg_q;
   logic            neg_r;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] opnd;

   logic            a_sgn;
   logic            b_sgn;
   logic            div_zero;
   logic            div_ovf;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN-1:0] fast_res;

   always_comb begin
      a_sgn    = is_signed_a(op) & a[XLEN-1];
      b_sgn    = is_signed_b(op) & b[XLEN-1];
      a_mag    = a_sgn ? ('0 - a) : a;
      b_mag    = b_sgn ? ('0 - b) : b;
      div_zero = op[2] & (b == '0);
      div_ovf  = ((op == M_DIV) || (op == M_REM)) & (a == MIN_NEG) & (b == '1);
      // op[1] separates REM/REMU from DIV/DIVU
      if (op[1]) fast_res = div_zero ? a : '0;
      else       fast_res = div_zero ? '1 : a;
   end

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shl;
   logic [XLEN:0]     div_trial;
   logic [XLEN-1:0]   hi_n;
   logic [XLEN-1:0]   lo_n;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   q_fix;
   logic [XLEN-1:0]   r_fix;
   logic [XLEN-1:0]   final_res;

   // hi/lo hold {partial product, multiplier} or {remainder, quotient}
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      div_shl   = {hi, lo[XLEN-1]};
      div_trial = div_shl - {1'b0, opnd};
      if (op_q[2]) begin
         if (!div_trial[XLEN]) begin
            hi_n = div_trial[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b1};
         end else begin
            hi_n = div_shl[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_n = mul_sum[XLEN:1];
         lo_n = {mul_sum[0], lo[XLEN-1:1]};
      end
      prod_fix = neg_q ? ('0 - {hi_n, lo_n}) : {hi_n, lo_n};
      q_fix    = neg_q ? ('0 - lo_n) : lo_n;
      r_fix    = neg_r ? ('0 - hi_n) : hi_n;
      case (op_q)
         M_MUL:                     final_res = prod_fix[XLEN-1:0];
         M_MULH, M_MULHSU, M_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
         M_DIV, M_DIVU:             final_res = q_fix;
         default:                   final_res = r_fix;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         op_q   <= M_MUL;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         opnd   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_q  <= op;
                  neg_q <= a_sgn ^ b_sgn;
                  neg_r <= a_sgn;
                  if (div_zero || div_ovf) begin
                     result <= fast_res;
                     done   <= 1'b1;
                     state  <= ST_DONE;
                  end else begin
                     hi    <= '0;
                     lo    <= op[2] ? a_mag : b_mag;
                     opnd  <= op[2] ? b_mag : a_mag;
                     cnt   <= CW'(XLEN - 1);
                     busy  <= 1'b1;
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (!valid_i) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  hi  <= hi_n;
                  lo  <= lo_n;
                  cnt <= cnt - CW'(1);
                  if (cnt == '0) begin
                     result <= final_res;
                     done   <= 1'b1;
                     busy   <= 1'b0;
                     state  <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decoder with optional RV M-extension sequencer; stalls the PC
// while a MUL/DIV is in flight and steers writeback to md_result.
module alu_ctrl_muldiv
   import alu_ctrl_muldiv_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter bit          ENABLE_M = 1'b1
) (
   input logic               clk,
   input logic               rst,
   alu_ctrl_muldiv_if.slave  bus
);

   logic     md_req;
   alu_sel_e sel;

   assign md_req = ENABLE_M & bus.valid_i & bus.rtype & (bus.alu_op == ALUOP_FUNCT) & bus.funct7_0;

   always_comb begin
      sel = ALU_ADD;
      case (aluop_e'(bus.alu_op))
         ALUOP_ADD:  sel = ALU_ADD;
         ALUOP_SUB:  sel = ALU_SUB;
         ALUOP_PASS: sel = ALU_PASS;
         ALUOP_FUNCT: begin
            case (bus.funct3)
               3'b000:  sel = (bus.rtype & ~bus.itype & bus.funct7_5) ? ALU_SUB : ALU_ADD;
               3'b001:  sel = ALU_SLL;
               3'b010:  sel = ALU_SLT;
               3'b011:  sel = ALU_SLTU;
               3'b100:  sel = ALU_XOR;
               3'b101:  sel = bus.funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110:  sel = ALU_OR;
               3'b111:  sel = ALU_AND;
               default: sel = ALU_ADD;
            endcase
         end
         default: sel = ALU_ADD;
      endcase
      if (md_req) sel = ALU_ADD;
   end

   assign bus.alu_sel = sel;

   generate
      if (ENABLE_M) begin : g_m
         logic            busy_w;
         logic            done_w;
         logic [XLEN-1:0] res_w;

         seq_muldiv_core #(.XLEN(XLEN)) u_core (
            .clk     (clk),
            .rst     (rst),
            .start   (md_req),
            .valid_i (bus.valid_i),
            .op      (mop_e'(bus.funct3)),
            .a       (bus.rs1_val),
            .b       (bus.rs2_val),
            .busy    (busy_w),
            .done    (done_w),
            .result  (res_w)
         );

         // done is high exactly while the sequencer sits in DONE
         assign bus.stall     = md_req & ~done_w;
         assign bus.md_sel    = md_req;
         assign bus.md_busy   = busy_w;
         assign bus.md_done   = done_w;
         assign bus.md_result = res_w;
      end else begin : g_nom
         assign bus.stall     = 1'b0;
         assign bus.md_sel    = 1'b0;
         assign bus.md_busy   = 1'b0;
         assign bus.md_done   = 1'b0;
         assign bus.md_result = '0;
      end
   endgenerate

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed bench for alu_ctrl_muldiv at XLEN 32 and 64 with an arithmetic
// reference model and a per-cycle output compare.
module tb_alu_ctrl_muldiv;
   import alu_ctrl_muldiv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_ctrl_muldiv_if #(.XLEN(32)) bi32 ();
   alu_ctrl_muldiv_if #(.XLEN(64)) bi64 ();

   alu_ctrl_muldiv #(.XLEN(32), .ENABLE_M(1'b1)) dut32 (.clk(clk), .rst(rst), .bus(bi32));
   alu_ctrl_muldiv #(.XLEN(64), .ENABLE_M(1'b1)) dut64 (.clk(clk), .rst(rst), .bus(bi64));

   // model state per DUT (0 = XLEN 32, 1 = XLEN 64)
   bit          act[2];
   bit          req_on[2];
   int          t0[2];
   int          lat[2];
   logic [63:0] exp_res[2];
   logic [63:0] last_res[2];

   function automatic void chk(string nm, logic [63:0] got, logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, want);
      end
   endfunction

   function automatic logic [63:0] ref_md(int xlen, logic [2:0] f3, logic [63:0] a_in, logic [63:0] b_in);
      logic [63:0]        mask;
      logic [63:0]        a;
      logic [63:0]        b;
      logic signed [129:0] ua, ub, sa, sb, r;
      logic               ovf;
      mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      a  = a_in & mask;
      b  = b_in & mask;
      ua = {66'b0, a};
      ub = {66'b0, b};
      sa = ua;
      sb = ub;
      if (a[xlen-1]) sa = ua - (130'sd1 <<< xlen);
      if (b[xlen-1]) sb = ub - (130'sd1 <<< xlen);
      ovf = (a == (64'd1 << (xlen - 1))) && (b == mask);
      case (f3)
         3'd0: r = sa * sb;
         3'd1: r = (sa * sb) >>> xlen;
         3'd2: r = (sa * ub) >>> xlen;
         3'd3: r = (ua * ub) >>> xlen;
         3'd4: r = (b == 0) ? -130'sd1 : (ovf ? sa : sa / sb);
         3'd5: r = (b == 0) ? -130'sd1 : ua / ub;
         3'd6: r = (b == 0) ? sa : (ovf ? 130'sd0 : sa % sb);
         default: r = (b == 0) ? ua : ua % ub;
      endcase
      return r[63:0] & mask;
   endfunction

   function automatic int md_lat(int xlen, logic [2:0] f3, logic [63:0] a_in, logic [63:0] b_in);
      logic [63:0] mask;
      mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      if (f3[2] && ((b_in & mask) == 0)) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && ((a_in & mask) == (64'd1 << (xlen - 1))) && ((b_in & mask) == mask))
         return 1;
      return xlen + 1;
   endfunction

   function automatic logic [63:0] res_of(int k);
      return (k == 0) ? {32'b0, bi32.md_result} : bi64.md_result;
   endfunction

   task automatic set_in(input int k, input logic v, input logic [1:0] op, input logic [2:0] f3,
                         input logic f75, input logic f70, input logic rt, input logic it,
                         input logic [63:0] a, input logic [63:0] b);
      if (k == 0) begin
         bi32.valid_i = v; bi32.alu_op = op; bi32.funct3 = f3; bi32.funct7_5 = f75;
         bi32.funct7_0 = f70; bi32.rtype = rt; bi32.itype = it;
         bi32.rs1_val = a[31:0]; bi32.rs2_val = b[31:0];
      end else begin
         bi64.valid_i = v; bi64.alu_op = op; bi64.funct3 = f3; bi64.funct7_5 = f75;
         bi64.funct7_0 = f70; bi64.rtype = rt; bi64.itype = it;
         bi64.rs1_val = a; bi64.rs2_val = b;
      end
   endtask

   task automatic issue(input int k, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
      int xl;
      xl = (k == 0) ? 32 : 64;
      set_in(k, 1'b1, 2'b10, f3, 1'b0, 1'b1, 1'b1, 1'b0, a, b);
      exp_res[k] = ref_md(xl, f3, a, b);
      lat[k]     = md_lat(xl, f3, a, b);
      t0[k]      = cyc;
      act[k]     = 1'b1;
      req_on[k]  = 1'b1;
   endtask

   task automatic retire(input int k);
      act[k]    = 1'b0;
      req_on[k] = 1'b0;
      set_in(k, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
   endtask

   // Full M operation; lit pins both the model and the DUT result.
   task automatic do_md(input int k, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] lit);
      issue(k, f3, a, b);
      chk("model_pin", exp_res[k], lit);
      repeat (lat[k]) @(posedge clk);
      @(negedge clk);
      chk("md_result_lit", res_of(k), lit);
      @(posedge clk); #1;
      retire(k);
   endtask

   task automatic dec(input logic v, input logic [1:0] op, input logic [2:0] f3, input logic f75,
                      input logic f70, input logic rt, input logic it, input logic [3:0] want);
      set_in(0, v, op, f3, f75, f70, rt, it, 64'd1, 64'd2);
      @(negedge clk);
      chk("alu_sel_decode", bi32.alu_sel, want);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Per-cycle compare of every output against the model
   always @(negedge clk) begin
      logic [63:0] g_res;
      logic        g_done, g_stall, g_busy, g_sel;
      logic [3:0]  g_alu;
      int          d;
      logic        e_done, e_busy, e_stall;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            g_res = {32'b0, bi32.md_result}; g_done = bi32.md_done; g_stall = bi32.stall;
            g_busy = bi32.md_busy; g_sel = bi32.md_sel; g_alu = bi32.alu_sel;
         end else begin
            g_res = bi64.md_result; g_done = bi64.md_done; g_stall = bi64.stall;
            g_busy = bi64.md_busy; g_sel = bi64.md_sel; g_alu = bi64.alu_sel;
         end
         if (rst) last_res[k] = '0;
         d       = cyc - t0[k];
         e_done  = act[k] && !rst && (d == lat[k]);
         e_busy  = act[k] && !rst && (lat[k] > 1) && (d >= 1) && (d < lat[k]);
         e_stall = req_on[k] && !e_done;
         chk($sformatf("md_done[%0d]", k), g_done, e_done);
         chk($sformatf("md_busy[%0d]", k), g_busy, e_busy);
         chk($sformatf("stall[%0d]", k), g_stall, e_stall);
         chk($sformatf("md_sel[%0d]", k), g_sel, req_on[k]);
         chk($sformatf("md_result[%0d]", k), g_res, e_done ? exp_res[k] : last_res[k]);
         if (req_on[k]) chk($sformatf("alu_sel_md[%0d]", k), g_alu, ALU_ADD);
         if (e_done) last_res[k] = exp_res[k];
      end
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         act[k] = 1'b0; req_on[k] = 1'b0; t0[k] = 0; lat[k] = 0;
         exp_res[k] = '0; last_res[k] = '0;
         retire(k);
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(1);

      // decode sweep
      dec(1, 2'b10, 3'b101, 1, 0, 1, 0, ALU_SRA);
      dec(1, 2'b10, 3'b101, 0, 0, 1, 0, ALU_SRL);
      dec(1, 2'b10, 3'b000, 1, 0, 1, 0, ALU_SUB);
      dec(1, 2'b10, 3'b000, 1, 0, 0, 1, ALU_ADD);
      dec(1, 2'b10, 3'b000, 0, 0, 1, 0, ALU_ADD);
      dec(1, 2'b10, 3'b001, 0, 0, 1, 0, ALU_SLL);
      dec(1, 2'b10, 3'b010, 0, 0, 1, 0, ALU_SLT);
      dec(1, 2'b10, 3'b011, 0, 0, 1, 0, ALU_SLTU);
      dec(1, 2'b10, 3'b100, 0, 0, 1, 0, ALU_XOR);
      dec(1, 2'b10, 3'b110, 0, 0, 1, 0, ALU_OR);
      dec(1, 2'b10, 3'b111, 0, 0, 1, 0, ALU_AND);
      dec(1, 2'b00, 3'b111, 1, 0, 1, 0, ALU_ADD);
      dec(1, 2'b01, 3'b000, 0, 0, 0, 0, ALU_SUB);
      dec(1, 2'b11, 3'b000, 0, 0, 0, 0, ALU_PASS);
      dec(1, 2'b10, 3'b100, 0, 1, 0, 1, ALU_XOR);
      dec(0, 2'b10, 3'b100, 0, 1, 1, 0, ALU_XOR);
      retire(0);

      // multiply, back-to-back
      do_md(0, 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_FFFF_FFEB);
      do_md(0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFE);
      do_md(0, 3'd1, 64'h8000_0000, 64'h8000_0000, 64'h0000_0000_4000_0000);
      do_md(0, 3'd2, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0000_0000_8000_0000);

      // divide / remainder
      do_md(0, 3'd4, 64'hFFFF_FFF9, 64'd2, 64'h0000_0000_FFFF_FFFD);
      do_md(0, 3'd6, 64'hFFFF_FFF9, 64'd2, 64'h0000_0000_FFFF_FFFF);
      do_md(0, 3'd5, 64'd100, 64'd7, 64'd14);
      do_md(0, 3'd7, 64'd100, 64'd7, 64'd2);

      // fast paths
      do_md(0, 3'd4, 64'd5, 64'd0, 64'h0000_0000_FFFF_FFFF);
      do_md(0, 3'd6, 64'd5, 64'd0, 64'd5);
      do_md(0, 3'd5, 64'd5, 64'd0, 64'h0000_0000_FFFF_FFFF);
      do_md(0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0000_0000_8000_0000);
      do_md(0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0);
      idle(1);

      // reset mid-CALC after a nonzero result
      do_md(0, 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_FFFF_FFEB);
      issue(0, 3'd4, 64'hFFFF_FFF9, 64'd2);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      act[0] = 1'b0;
      @(negedge clk);
      chk("md_result_in_reset", bi32.md_result, 64'd0);
      chk("md_busy_in_reset", bi32.md_busy, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      retire(0);
      idle(2);

      // flush mid-CALC, then a clean request
      issue(0, 3'd4, 64'd100, 64'd7);
      repeat (5) @(posedge clk);
      #1;
      set_in(0, 1'b0, 2'b10, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 64'd100, 64'd7);
      req_on[0] = 1'b0;
      @(posedge clk); #1;
      act[0] = 1'b0;
      retire(0);
      idle(3);
      do_md(0, 3'd4, 64'd100, 64'hFFFF_FFF9, 64'h0000_0000_FFFF_FFF2);
      do_md(0, 3'd6, 64'd100, 64'hFFFF_FFF9, 64'd2);

      // XLEN 64
      do_md(1, 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
      do_md(1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
      do_md(1, 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
      do_md(1, 3'd6, 64'd5, 64'd0, 64'd5);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_muldiv.md
Name: alu_ctrl_muldiv

Overview:
- Next-generation ALU control for the RISC-V core, parametrised in data width (XLEN).
- Decodes ALUOp/funct3/funct7 into the 4-bit ALU selection, same as the current single-cycle decoder.
- Adds RV32M/RV64M support through an iterative multiply/divide sequencer.
- Sits between the control unit and the EX stage; it stalls the PC while a MUL/DIV is in flight and supplies the result to the writeback mux.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- ENABLE_M, 1, 0 = M-extension disabled: M encodings decode as plain R-type and md_req is never raised.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- valid_i  in  1  instruction in decode is valid
- alu_op  in  2  ALUOp from the main control unit
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- funct7_0  in  1  instr[25] (M-extension select)
- rtype  in  1  R-type instruction
- itype  in  1  I-type ALU instruction
- rs1_val  in  XLEN  source operand 1
- rs2_val  in  XLEN  source operand 2
- alu_sel  out  4  ALU_* selection
- md_sel  out  1  writeback takes md_result instead of the ALU result
- stall  out  1  hold PC and instruction
- md_busy  out  1  sequencer is in CALC
- md_done  out  1  one-cycle pulse, md_result valid
- md_result  out  XLEN  MUL/DIV/REM result

Behaviour:
- Decode (combinational):
  - ALUOp 00 -> ADD; 01 -> SUB; 11 -> PASS.
  - ALUOp 10: funct3 000 -> SUB only when rtype & funct7_5, otherwise ADD; 001 -> SLL; 101 -> SRA if funct7_5, else SRL; 100 -> XOR; 110 -> OR; 111 -> AND; 010 -> SLT; 011 -> SLTU.
  - Any undefined combination -> ADD. No latch is inferred.
- md_req = ENABLE_M & valid_i & rtype & alu_op==10 & funct7_0. When md_req is high, alu_sel = ADD and md_sel = 1.
- M funct3 mapping: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, CALC, DONE.
  - IDLE: when md_req is high, latch operand magnitudes, sign flags and op; load the counter with XLEN-1; go to CALC. Fast paths go directly to DONE.
  - CALC: one radix-2 step per cycle (shift-add multiply on a 2*XLEN product register; restoring divide). md_busy = 1. When the counter reaches 0 -> DONE.
  - DONE: apply the sign fixup, register md_result, md_done = 1 for one cycle, then -> IDLE.
- stall = md_req & ~(state==DONE). It is asserted combinationally in the request cycle.
- Latency: request accepted in cycle 0, md_done in cycle XLEN+1. Fast paths give md_done in cycle 1.
- Back-to-back: an M instruction following DONE is accepted in the next IDLE cycle; there is no dead cycle beyond that.
- Result selection:
  - MUL takes the low XLEN bits of the product.
  - MULH/MULHSU/MULHU take the high XLEN bits with signed/signed, signed/unsigned and unsigned/unsigned interpretation.
  - DIV/REM quotient and remainder are negated as required. The remainder sign follows the dividend.
- Fast path, divide by zero: quotient = all ones, remainder = rs1.
- Fast path, signed overflow (DIV/REM of -2^(XLEN-1) by -1): quotient = rs1, remainder = 0.
- Flush: valid_i low during CALC aborts to IDLE. md_done is not pulsed and md_result holds its old value.
- Reset (any state, including mid-CALC): state IDLE, counter 0, md_result 0, md_busy 0, md_done 0. stall then follows md_req.
- md_result holds its value until the next DONE.
- ENABLE_M = 0: the FSM is removed; stall, md_busy, md_done, md_sel and md_result are tied to 0.

Decomposition:
- Shared package/defines: ALU_* select codes (existing values), M funct3 constants, FSM state encodings, ALUOp encodings.
- One natural sub-module: seq_muldiv_core (XLEN-parametrised iterative datapath plus counter).
- The decoder and stall logic stay in alu_ctrl_muldiv.

Test Plan:
1. Decode sweep: ALUOp 10, funct3 101, funct7_5 = 1 -> SRA. rtype, funct3 000, funct7_5 = 1 -> SUB. itype, funct3 000, funct7_5 = 1 -> ADD. ALUOp 11 -> PASS.
2. MUL 7 * -3 (XLEN 32) -> stall high for cycles 0..32, md_done at cycle 33, md_result 0xFFFFFFEB. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
3. DIV -7 / 2 -> 0xFFFFFFFD. REM -7 / 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
4. DIV 5 / 0 -> md_done at cycle 1, result 0xFFFFFFFF. REM 5 / 0 -> 5. DIV 0x80000000 / -1 -> 0x80000000 at cycle 1.
5. Assert rst at cycle 10 of a DIV -> md_busy 0 and md_result 0 immediately, with no md_done pulse. Drop valid_i mid-CALC -> abort, next request starts cleanly.
6. Two MULs back-to-back, then XLEN = 64 rerun of scenario 2 -> md_done at cycles 33 and 67 (XLEN 32); at cycle 65 for XLEN 64 with the correct 64-bit results.
